// File: rtl/pcileech_cfgspace_cpl_tx_if.sv
// ---------------------------------------------------------------------------
// pcileech_cfgspace_cpl_tx_if
//   AXI-Stream style TLP beat channel between the config-space completion
//   builder and the PCIe TX arbiter.
//
//   tdata   128  TLP beat, DW0 in [31:0]
//   tkeep   4    DW-granular keep
//   tlast   1    end of TLP (always 1 with tvalid: every TLP is one beat)
//   tvalid  1    beat available
//   tready  1    downstream accepts the beat
//
//   modport master : beat source (drives tdata/tkeep/tlast/tvalid)
//   modport slave  : beat sink   (drives tready)
// ---------------------------------------------------------------------------
interface pcileech_cfgspace_cpl_tx_if;
    logic [127:0] tdata;
    logic [3:0]   tkeep;
    logic         tlast;
    logic         tvalid;
    logic         tready;

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/pcileech_cfgspace_cpl_tx.sv
// ---------------------------------------------------------------------------
// pcileech_cfgspace_cpl_tx
//   Builds one single-beat 128-bit completion TLP per accepted config-space
//   request (CplD for CfgRd, Cpl for CfgWr), buffers it in a small FIFO and
//   presents it to the TX arbiter over an AXI-Stream source.
//
// Parameters
//   FIFO_DEPTH      completion buffer entries (power of 2, 2..16)
//
// Optional feature
//   CFG_TX_UR_EN    when defined, a request flagged with pcie_rx_status[1]
//                   (bad address/function) completes as Unsupported Request:
//                   Cpl format, status 3'b001, byte count 0, even for CfgRd.
//                   When undefined, pcie_rx_status[1] is ignored.
//
// Ports
//   clk_pcie        PCIe user clock
//   rst_n           asynchronous active-low reset
//   pcie_id         completer ID {bus,dev,fn}, captured at enqueue
//   pcie_rx_status  [2]=no valid request, [1]=bad addr/function, [0]=unused
//   cfg_wren        enqueue a completion this cycle
//   cfg_tlpwr       1=CfgWr (Cpl), 0=CfgRd (CplD)
//   cfg_tag         request tag
//   cfg_data        read data returned in a CplD
//   cfg_reqid       requester ID
//   tx              TLP beat stream (master side)
//   ovf             sticky: a request was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module pcileech_cfgspace_cpl_tx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk_pcie,
    input  logic                              rst_n,
    input  logic [15:0]                       pcie_id,
    input  logic [2:0]                        pcie_rx_status,
    input  logic                              cfg_wren,
    input  logic                              cfg_tlpwr,
    input  logic [7:0]                        cfg_tag,
    input  logic [31:0]                       cfg_data,
    input  logic [15:0]                       cfg_reqid,
    pcileech_cfgspace_cpl_tx_if.master        tx,
    output logic                              ovf
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [31:0] DW0_CPLD = 32'h4A00_0001;  // fmt 010, type 01010, len 1
    localparam logic [31:0] DW0_CPL  = 32'h0A00_0000;  // fmt 000, type 01010, len 0
    localparam logic [2:0]  ST_SC    = 3'b000;
    localparam logic [2:0]  ST_UR    = 3'b001;

    // One buffered completion: the fully formed beat plus whether it is a
    // data-less Cpl, which is all that is needed to derive tkeep on the way out.
    typedef struct packed {
        logic         is_cpl;
        logic [127:0] tdata;
    } entry_t;

    entry_t              mem [FIFO_DEPTH];
    entry_t              new_entry;
    entry_t              head;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;

    logic                is_ur;
    logic                enq_req;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic                unused_status;

`ifdef CFG_TX_UR_EN
    assign is_ur = pcie_rx_status[1];
`else
    assign is_ur = 1'b0;
`endif

    // Status bit 0 is reserved; bit 1 only matters with the UR feature.
    assign unused_status = ^pcie_rx_status[1:0];

    // ---------------------------------------------------------------------
    // Header assembly from the request fields as they stand at enqueue.
    // ---------------------------------------------------------------------
    always_comb begin
        logic        cpl_fmt;
        logic [2:0]  status;
        logic [11:0] byte_count;
        logic [31:0] dw0, dw1, dw2, dw3;

        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        cpl_fmt    = cfg_tlpwr | is_ur;
        status     = is_ur ? ST_UR : ST_SC;
        byte_count = is_ur ? 12'd0 : 12'd4;

        dw0 = cpl_fmt ? DW0_CPL : DW0_CPLD;
        dw1 = {pcie_id, status, 1'b0, byte_count};
        dw2 = {cfg_reqid, cfg_tag, 1'b0, 7'd0};
        dw3 = cpl_fmt ? 32'd0 : cfg_data;

        new_entry.is_cpl = cpl_fmt;
        new_entry.tdata  = {dw3, dw2, dw1, dw0};
    end

    // ---------------------------------------------------------------------
    // FIFO control. A full FIFO still accepts a push in the same cycle the
    // head is drained, so a steady stream at full rate never drops.
    // ---------------------------------------------------------------------
    assign enq_req = cfg_wren & ~pcie_rx_status[2];
    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign pop     = ~empty & tx.tready;
    assign push    = enq_req & (~full | pop);

    // NOTE: the storage array has no reset; an entry is only ever read while
    // count says it holds valid data, so clearing it would buy nothing.
    always_ff @(posedge clk_pcie) begin
        if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_pcie or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;  // power-of-2 depth: wraps naturally
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (enq_req && full && !pop) begin
                ovf <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stream output straight from the FIFO head. Everything here derives
    // from count/rd_ptr, so an async reset clears tvalid immediately, and
    // tdata/tkeep read as zero whenever nothing is queued.
    // ---------------------------------------------------------------------
    assign head      = mem[rd_ptr];
    assign tx.tvalid = ~empty;
    assign tx.tlast  = ~empty;
    assign tx.tkeep  = empty ? 4'b0000 : (head.is_cpl ? 4'b0111 : 4'b1111);
    assign tx.tdata  = empty ? 128'd0 : head.tdata;

endmodule

// File: tb/tb_pcileech_cfgspace_cpl_tx.sv
// ---------------------------------------------------------------------------
// tb_pcileech_cfgspace_cpl_tx
//   Directed bench for the config-space completion builder (FIFO_DEPTH=4).
//   Inputs change on the falling edge; outputs are compared on the falling
//   edge, half a cycle away from the rising edge that updates them.
// ---------------------------------------------------------------------------
module tb_pcileech_cfgspace_cpl_tx;

    logic        clk_pcie = 1'b0;
    logic        rst_n    = 1'b0;
    logic [15:0] pcie_id  = 16'h0100;
    logic [2:0]  pcie_rx_status = 3'b000;
    logic        cfg_wren  = 1'b0;
    logic        cfg_tlpwr = 1'b0;
    logic [7:0]  cfg_tag   = 8'h00;
    logic [31:0] cfg_data  = 32'h0;
    logic [15:0] cfg_reqid = 16'h0;
    logic        ovf;

    int vectors     = 0;
    int miscompares = 0;

    pcileech_cfgspace_cpl_tx_if tx_if ();

    pcileech_cfgspace_cpl_tx #(.FIFO_DEPTH(4)) dut (
        .clk_pcie       (clk_pcie),
        .rst_n          (rst_n),
        .pcie_id        (pcie_id),
        .pcie_rx_status (pcie_rx_status),
        .cfg_wren       (cfg_wren),
        .cfg_tlpwr      (cfg_tlpwr),
        .cfg_tag        (cfg_tag),
        .cfg_data       (cfg_data),
        .cfg_reqid      (cfg_reqid),
        .tx             (tx_if.master),
        .ovf            (ovf)
    );

    always #5 clk_pcie = ~clk_pcie;

    // Present one request for exactly one rising edge; call on a falling edge.
    task automatic enq(input logic wr, input logic [7:0] tag, input logic [15:0] reqid,
                       input logic [31:0] data, input logic [2:0] st);
        cfg_tlpwr      = wr;
        cfg_tag        = tag;
        cfg_reqid      = reqid;
        cfg_data       = data;
        pcie_rx_status = st;
        cfg_wren       = 1'b1;
        @(negedge clk_pcie);
        cfg_wren       = 1'b0;
        pcie_rx_status = 3'b000;
    endtask

    task automatic do_reset();
        tx_if.tready = 1'b0;
        cfg_wren     = 1'b0;
        rst_n        = 1'b0;
        repeat (2) @(negedge clk_pcie);
        rst_n = 1'b1;
        @(negedge clk_pcie);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (tx_if.tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid got=%b exp=0", tx_if.tvalid); end
        vectors++;
        if (tx_if.tdata !== 128'd0) begin miscompares++; $display("FAIL reset_tdata got=%h exp=0", tx_if.tdata); end
        vectors++;
        if (tx_if.tkeep !== 4'h0 || tx_if.tlast !== 1'b0) begin
            miscompares++; $display("FAIL reset_tkeep_tlast got=%h/%b exp=0/0", tx_if.tkeep, tx_if.tlast);
        end
        vectors++;
        if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    endtask

    task automatic test_cfgrd();
        logic [127:0] exp;
        exp = {32'h12345678, 32'h00000500, 32'h01000004, 32'h4A000001};
        pcie_id = 16'h0100;
        enq(1'b0, 8'h05, 16'h0000, 32'h12345678, 3'b000);
        vectors++;
        if (tx_if.tvalid !== 1'b1) begin miscompares++; $display("FAIL cfgrd_latency tvalid got=%b exp=1", tx_if.tvalid); end
        vectors++;
        if (tx_if.tdata !== exp) begin miscompares++; $display("FAIL cfgrd_tdata got=%h exp=%h", tx_if.tdata, exp); end
        vectors++;
        if (tx_if.tkeep !== 4'hF || tx_if.tlast !== 1'b1) begin
            miscompares++; $display("FAIL cfgrd_tkeep_tlast got=%h/%b exp=f/1", tx_if.tkeep, tx_if.tlast);
        end
        tx_if.tready = 1'b1;
        @(negedge clk_pcie);
        tx_if.tready = 1'b0;
        vectors++;
        if (tx_if.tvalid !== 1'b0 || tx_if.tkeep !== 4'h0) begin
            miscompares++; $display("FAIL cfgrd_drained tvalid/tkeep got=%b/%h exp=0/0", tx_if.tvalid, tx_if.tkeep);
        end
    endtask

    task automatic test_cfgwr();
        logic [127:0] exp;
        exp = {32'h00000000, 32'h00100700, 32'h01000004, 32'h0A000000};
        pcie_id = 16'h0100;
        enq(1'b1, 8'h07, 16'h0010, 32'hDEADBEEF, 3'b000);
        // Completer ID must have been captured at enqueue.
        pcie_id = 16'hBEEF;
        @(negedge clk_pcie);
        vectors++;
        if (tx_if.tdata !== exp) begin miscompares++; $display("FAIL cfgwr_tdata got=%h exp=%h", tx_if.tdata, exp); end
        vectors++;
        if (tx_if.tkeep !== 4'h7 || tx_if.tvalid !== 1'b1) begin
            miscompares++; $display("FAIL cfgwr_tkeep_tvalid got=%h/%b exp=7/1", tx_if.tkeep, tx_if.tvalid);
        end
        pcie_id = 16'h0100;
        tx_if.tready = 1'b1;
        @(negedge clk_pcie);
        tx_if.tready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            enq(1'b0, 8'(i), 16'h1234, 32'hA000_0000 + 32'(i), 3'b000);
        end
        vectors++;
        if (ovf !== 1'b0) begin miscompares++; $display("FAIL bp_ovf_before_drop got=%b exp=0", ovf); end
        enq(1'b0, 8'd4, 16'h1234, 32'hA000_0004, 3'b000);
        vectors++;
        if (ovf !== 1'b1) begin miscompares++; $display("FAIL bp_ovf_after_drop got=%b exp=1", ovf); end
        vectors++;
        if (tx_if.tdata[79:72] !== 8'd0) begin miscompares++; $display("FAIL bp_head_stable tag got=%h exp=00", tx_if.tdata[79:72]); end
        tx_if.tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (tx_if.tvalid !== 1'b1 || tx_if.tdata[79:72] !== 8'(i) || tx_if.tdata[127:96] !== 32'hA000_0000 + 32'(i)) begin
                miscompares++;
                $display("FAIL bp_drain_%0d tvalid/tag/data got=%b/%h/%h exp=1/%h/%h", i, tx_if.tvalid,
                         tx_if.tdata[79:72], tx_if.tdata[127:96], 8'(i), 32'hA000_0000 + 32'(i));
            end
            @(negedge clk_pcie);
        end
        vectors++;
        if (tx_if.tvalid !== 1'b0) begin miscompares++; $display("FAIL bp_empty_after_drain tvalid got=%b exp=0", tx_if.tvalid); end
        vectors++;
        if (ovf !== 1'b1) begin miscompares++; $display("FAIL bp_ovf_sticky got=%b exp=1", ovf); end
        tx_if.tready = 1'b0;
    endtask

    task automatic test_full_bypass();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            enq(1'b1, 8'(8'h10 + i), 16'h0042, 32'h0, 3'b000);
        end
        // Full: push and pop on the same edge.
        tx_if.tready = 1'b1;
        enq(1'b1, 8'h14, 16'h0042, 32'h0, 3'b000);
        tx_if.tready = 1'b0;
        vectors++;
        if (ovf !== 1'b0) begin miscompares++; $display("FAIL bypass_ovf got=%b exp=0", ovf); end
        tx_if.tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (tx_if.tvalid !== 1'b1 || tx_if.tdata[79:72] !== 8'(8'h11 + i)) begin
                miscompares++;
                $display("FAIL bypass_drain_%0d tvalid/tag got=%b/%h exp=1/%h", i, tx_if.tvalid,
                         tx_if.tdata[79:72], 8'(8'h11 + i));
            end
            @(negedge clk_pcie);
        end
        vectors++;
        if (tx_if.tvalid !== 1'b0) begin miscompares++; $display("FAIL bypass_occupancy tvalid got=%b exp=0", tx_if.tvalid); end
        tx_if.tready = 1'b0;
    endtask

    task automatic test_status();
        do_reset();
        enq(1'b0, 8'h22, 16'h0001, 32'h55AA55AA, 3'b100);
        vectors++;
        if (tx_if.tvalid !== 1'b0) begin miscompares++; $display("FAIL status_novalid tvalid got=%b exp=0", tx_if.tvalid); end
        enq(1'b0, 8'h23, 16'h0001, 32'h55AA55AA, 3'b010);
`ifdef CFG_TX_UR_EN
        vectors++;
        if (tx_if.tdata[47:45] !== 3'b001 || tx_if.tkeep !== 4'h7) begin
            miscompares++; $display("FAIL status_ur status/tkeep got=%b/%h exp=001/7", tx_if.tdata[47:45], tx_if.tkeep);
        end
        vectors++;
        if (tx_if.tdata[31:0] !== 32'h0A000000 || tx_if.tdata[43:32] !== 12'd0 || tx_if.tdata[127:96] !== 32'd0) begin
            miscompares++; $display("FAIL status_ur_fields dw0/bc/dw3 got=%h/%h/%h exp=0a000000/000/0",
                                    tx_if.tdata[31:0], tx_if.tdata[43:32], tx_if.tdata[127:96]);
        end
`else
        vectors++;
        if (tx_if.tdata[47:45] !== 3'b000 || tx_if.tkeep !== 4'hF) begin
            miscompares++; $display("FAIL status_badaddr_ignored status/tkeep got=%b/%h exp=000/f", tx_if.tdata[47:45], tx_if.tkeep);
        end
        vectors++;
        if (tx_if.tdata[127:96] !== 32'h55AA55AA || tx_if.tdata[79:72] !== 8'h23) begin
            miscompares++; $display("FAIL status_badaddr_data data/tag got=%h/%h exp=55aa55aa/23",
                                    tx_if.tdata[127:96], tx_if.tdata[79:72]);
        end
`endif
        tx_if.tready = 1'b1;
        @(negedge clk_pcie);
        tx_if.tready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_keep [3];
        exp_keep = '{4'h7, 4'hF, 4'h7};
        tx_if.tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            enq((i != 1), 8'(8'h30 + i), 16'h0077, 32'hC0DE0000 + 32'(i), 3'b000);
            vectors++;
            if (tx_if.tvalid !== 1'b1 || tx_if.tkeep !== exp_keep[i] || tx_if.tdata[79:72] !== 8'(8'h30 + i)) begin
                miscompares++;
                $display("FAIL b2b_%0d tvalid/tkeep/tag got=%b/%h/%h exp=1/%h/%h", i, tx_if.tvalid,
                         tx_if.tkeep, tx_if.tdata[79:72], exp_keep[i], 8'(8'h30 + i));
            end
        end
        @(negedge clk_pcie);
        vectors++;
        if (tx_if.tvalid !== 1'b0) begin miscompares++; $display("FAIL b2b_empty tvalid got=%b exp=0", tx_if.tvalid); end
        tx_if.tready = 1'b0;
    endtask

    task automatic test_reset_mid();
        enq(1'b0, 8'h40, 16'h0001, 32'h1, 3'b000);
        enq(1'b0, 8'h41, 16'h0001, 32'h2, 3'b000);
        vectors++;
        if (tx_if.tvalid !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre tvalid got=%b exp=1", tx_if.tvalid); end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (tx_if.tvalid !== 1'b0) begin miscompares++; $display("FAIL rstmid_async tvalid got=%b exp=0", tx_if.tvalid); end
        @(negedge clk_pcie);
        rst_n = 1'b1;
        @(negedge clk_pcie);
        vectors++;
        if (tx_if.tvalid !== 1'b0 || tx_if.tkeep !== 4'h0 || tx_if.tdata !== 128'd0) begin
            miscompares++; $display("FAIL rstmid_empty tvalid/tkeep got=%b/%h exp=0/0", tx_if.tvalid, tx_if.tkeep);
        end
    endtask

    initial begin
        tx_if.tready = 1'b0;
        test_reset();
        test_cfgrd();
        test_cfgwr();
        test_backpressure();
        test_full_bypass();
        test_status();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
